// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared constants and helpers for the pipelined adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int c_default_width  = 32;
  localparam int c_default_stages = 4;
  localparam int c_max_width      = 1024;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // 0x7F..F in the low 'width' bits
  function automatic logic [c_max_width-1:0] signed_max(input int width);
    logic [c_max_width-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  // 0x80..0 in the low 'width' bits
  function automatic logic [c_max_width-1:0] signed_min(input int width);
    logic [c_max_width-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module   : adder_chunk
// Brief    : Combinational CW-bit ripple adder built from full-adder cells.
// Revision : 1.0 - initial release
// ============================================================================
module adder_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  logic w_c;

  always_comb begin
    sum = '0;
    w_c = cin;
    for (int i = 0; i < CW; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Brief    : Pipelined chunked adder/subtractor with valid/ready handshake.
//            Define ADDER_PIPE_SAT_EN to clamp the result on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = c_default_width,
  parameter int STAGES = c_default_stages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_cfg_err
    $error("adder_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] c_sat_max = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] c_sat_min = WIDTH'(signed_min(WIDTH));
`endif

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_in_vld;
  logic [STAGES-1:0] w_load;

  // A stage moves when it is empty or everything downstream moves.
  always_comb begin
    w_adv    = '0;
    w_in_vld = '0;
    w_adv[STAGES-1] = !r_valid[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) w_adv[k] = !r_valid[k] || w_adv[k+1];
    w_in_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) w_in_vld[k] = r_valid[k-1];
    w_load = w_adv & w_in_vld;
  end

  assign in_ready = w_adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= '0;
    else        r_valid <= (r_valid & ~w_adv) | (w_in_vld & w_adv);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM_IN = WIDTH - k * CW;   // operand bits not yet summed
    localparam int DONE   = (k + 1) * CW;     // result bits known after this stage

    logic [REM_IN-1:0] w_a;
    logic [REM_IN-1:0] w_b;
    logic              w_cin;
    logic [CW-1:0]     w_chunk;
    logic              w_cout;
    logic [DONE-1:0]   w_sum;
    logic [DONE-1:0]   w_sum_d;
    logic [DONE-1:0]   r_sum;
    logic              r_carry;

    if (k == 0) begin : g_src
      assign w_a   = a;
      assign w_b   = sub ? ~b : b;
      assign w_cin = sub | carry_in;
      assign w_sum = w_chunk;
    end else begin : g_src
      assign w_a   = g_stage[k-1].g_opnd.r_a;
      assign w_b   = g_stage[k-1].g_opnd.r_b;
      assign w_cin = g_stage[k-1].r_carry;
      assign w_sum = {w_chunk, g_stage[k-1].r_sum};
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a    (w_a[CW-1:0]),
      .b    (w_b[CW-1:0]),
      .cin  (w_cin),
      .sum  (w_chunk),
      .cout (w_cout)
    );

    if (k < STAGES - 1) begin : g_opnd
      logic [REM_IN-CW-1:0] r_a;
      logic [REM_IN-CW-1:0] r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_load[k]) begin
          r_a <= w_a[REM_IN-1:CW];
          r_b <= w_b[REM_IN-1:CW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic w_ovf;
      logic r_ovf;
      assign w_ovf = (w_a[REM_IN-1] == w_b[REM_IN-1]) && (w_chunk[CW-1] != w_a[REM_IN-1]);
`ifdef ADDER_PIPE_SAT_EN
      // On overflow both operand signs agree, so A's sign picks the rail.
      assign w_sum_d = w_ovf ? (w_a[REM_IN-1] ? c_sat_min : c_sat_max) : w_sum;
`else
      assign w_sum_d = w_sum;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ovf <= 1'b0;
        else if (w_load[k]) r_ovf <= w_ovf;
      end
    end else begin : g_mid
      assign w_sum_d = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum   <= '0;
        r_carry <= 1'b0;
      end else if (w_load[k]) begin
        r_sum   <= w_sum_d;
        r_carry <= w_cout;
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign sum       = g_stage[STAGES-1].r_sum;
  assign carry_out = g_stage[STAGES-1].r_carry;
  assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe
// Brief    : Self-checking bench for adder_pipe against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

  localparam int W = 32;
  localparam int S = 4;
  localparam longint c_smax = (longint'(1) <<< (W - 1)) - 1;
  localparam longint c_smin = -(longint'(1) <<< (W - 1));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    res_t m;
    logic lit;
    res_t l;
    logic chk_lat;
    int   acc;
  } sb_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    res_t         l;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  // Degenerate builds: single stage and one bit per stage.
  logic       x_valid = 1'b0;
  logic [7:0] x_a = '0;
  logic [7:0] x_b = '0;
  logic       x1_ir, x1_ov, x1_co, x1_of, x8_ir, x8_ov, x8_co, x8_of;
  logic [7:0] x1_sum, x8_sum;

  adder_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x1_ir),
    .a(x_a), .b(x_b), .sub(1'b0), .carry_in(1'b0),
    .out_valid(x1_ov), .out_ready(1'b1),
    .sum(x1_sum), .carry_out(x1_co), .overflow(x1_of)
  );

  adder_pipe #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x8_ir),
    .a(x_a), .b(x_b), .sub(1'b0), .carry_in(1'b0),
    .out_valid(x8_ov), .out_ready(1'b1),
    .sum(x8_sum), .carry_out(x8_co), .overflow(x8_of)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Signed/unsigned arithmetic on wide integers, independent of any chunking.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub, input logic mcin);
    res_t r;
    longint sa, sb, sres;
    longint unsigned t;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      r.sum  = ma - mb;
      r.cout = (ma >= mb);
      sres   = sa - sb;
    end else begin
      t      = longint'(ma) + longint'(mb) + longint'(mcin);
      r.sum  = t[W-1:0];
      r.cout = t[W];
      sres   = sa + sb + longint'(mcin);
    end
    r.ovf = (sres > c_smax) || (sres < c_smin);
`ifdef ADDER_PIPE_SAT_EN
    if (r.ovf) r.sum = (sres > c_smax) ? W'(c_smax) : W'(c_smin);
`endif
    return r;
  endfunction

  sb_t          q[$];
  int           cyc = 0;
  logic         cur_lit = 1'b0;
  res_t         cur_l;
  logic         cur_lat = 1'b0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_co, hold_of;
  logic         saw_full_stall = 1'b0;
  int           n_emit = 0;
  logic         bp_en = 1'b0;
  logic [3:0]   bp_pat = 4'b1001;
  int           bp_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_en ? bp_pat[bp_idx % 4] : 1'b1;
    bp_idx++;
  end

  // Compare process: everything sampled mid-cycle, transfers happen at the next edge.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (q.size() < S) || out_ready);
      if (q.size() == S && !out_ready) saw_full_stall = 1'b1;
      if (stall_prev) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_sum", sum, hold_sum);
        check("stall_carry", carry_out, hold_co);
        check("stall_overflow", overflow, hold_of);
      end
      if (out_valid) begin
        if (q.size() == 0) check("out_valid_with_empty_scoreboard", out_valid, 0);
        else if (out_ready) begin
          e = q.pop_front();
          n_emit++;
          check("sum", sum, e.m.sum);
          check("carry_out", carry_out, e.m.cout);
          check("overflow", overflow, e.m.ovf);
          if (e.lit) begin
            check("sum_literal", sum, e.l.sum);
            check("carry_literal", carry_out, e.l.cout);
            check("overflow_literal", overflow, e.l.ovf);
          end
          if (e.chk_lat) check("latency_edges", cyc + 1 - e.acc, S);
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_sum   = sum;
      hold_co    = carry_out;
      hold_of    = overflow;
      if (in_valid && in_ready) begin
        e.m       = model(a, b, sub, carry_in);
        e.lit     = cur_lit;
        e.l       = cur_l;
        e.chk_lat = cur_lat;
        e.acc     = cyc + 1;
        if (cur_lit) begin
          check("model_sum_vs_literal", e.m.sum, cur_l.sum);
          check("model_ovf_vs_literal", e.m.ovf, cur_l.ovf);
        end
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                      input logic tc, input logic lit, input res_t l, input logic lat);
    bit acc = 1'b0;
    a = ta; b = tb2; sub = ts; carry_in = tc;
    cur_lit = lit; cur_l = l; cur_lat = lat;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  vec_t vecs[8];
  res_t none = '{sum: '0, cout: 1'b0, ovf: 1'b0};

  initial begin
    int base;
    int lat1, lat8;
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0}};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}};
    vecs[5] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, '{32'h2222_2222, 1'b0, 1'b0}};
    vecs[6] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, '{32'h0000_0002, 1'b1, 1'b0}};
`ifdef ADDER_PIPE_SAT_EN
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1}};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, '{32'h8000_0000, 1'b1, 1'b1}};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h8000_0000, 1'b1, 1'b1}};
`else
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1}};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}};
`endif

    // Reset state
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_carry", carry_out, 0);
    check("reset_overflow", overflow, 0);
    check("reset_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time so latency is exact
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b1, vecs[i].l, 1'b1);
      drain();
    end

    // Back-pressure stream with the consumer toggling 1,0,0,1
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, none, 1'b0);
    drain();
    check("saw_full_stall", saw_full_stall, 1);
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++)
      send(32'h1000_0000 * (i + 1), 32'h0000_0011, 1'b0, 1'b0, 1'b0, none, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_sum", sum, 0);
    check("midreset_carry", carry_out, 0);
    check("midreset_overflow", overflow, 0);
    check("midreset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_emit;
    repeat (6) @(posedge clk);
    #1;
    send(vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].cin, 1'b1, vecs[0].l, 1'b1);
    drain();
    send(vecs[3].a, vecs[3].b, vecs[3].sub, vecs[3].cin, 1'b1, vecs[3].l, 1'b1);
    drain();
    check("beats_after_reset", n_emit - base, 2);

    // STAGES=1 and STAGES=8 builds: 0xFF + 0xFF
    x_a = 8'hFF;
    x_b = 8'hFF;
    x_valid = 1'b1;
    @(negedge clk);
    check("s1_in_ready", x1_ir, 1);
    check("s8_in_ready", x8_ir, 1);
    @(posedge clk);
    #1 x_valid = 1'b0;
    lat1 = -1;
    lat8 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (x1_ov && lat1 < 0) begin
        lat1 = c;
        check("s1_sum", x1_sum, 8'hFE);
        check("s1_carry", x1_co, 1);
      end
      if (x8_ov && lat8 < 0) begin
        lat8 = c;
        check("s8_sum", x8_sum, 8'hFE);
        check("s8_carry", x8_co, 1);
      end
      @(posedge clk);
      #1;
    end
    check("s1_latency", lat1, 1);
    check("s8_latency", lat8, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
